// File: rtl/key_encode_83.sv
// Debounced 8-to-3 keypad encoder with a level-valid flag, a one-cycle press
// strobe and a multi-key indicator.
module key_encode_83 #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keyin,
  output logic [2:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_multi
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    pat, pat_n;
  logic [7:0]    sync1, key_s;
  logic [2:0]    code_n;
  logic          valid_n, press_n, multi_n;

  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // Two-flop synchronizer; inverted so that 1 means pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      key_s <= '0;
    end else begin
      sync1 <= ~keyin;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_press <= 1'b0;
      key_multi <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pat       <= pat_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_press <= press_n;
      key_multi <= multi_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    code_n  = key_code;
    valid_n = key_valid;
    multi_n = key_multi;
    press_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_s != 8'd0) begin
          pat_n   = key_s;
          cnt_n   = '0;
          state_n = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (key_s == 8'd0) begin
          state_n = IDLE;
        end else if (key_s != pat) begin
          pat_n = key_s;
          cnt_n = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end else begin
          state_n = HELD;
          code_n  = lowest_index(pat);
          multi_n = more_than_one(pat);
          valid_n = 1'b1;
          press_n = 1'b1;
        end
      end
      HELD: begin
        if (key_s != pat) begin
          cnt_n   = '0;
          state_n = REL_DB;
        end
      end
      REL_DB: begin
        if (key_s == pat) begin
          state_n = HELD;
        end else if (key_s != 8'd0) begin
          cnt_n = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end else begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_encode_83.sv
// Directed bench for key_encode_83 with a short debounce window (4 cycles).
module tb_key_encode_83;

  logic       clk;
  logic       rst_n;
  logic [7:0] keyin;
  logic [2:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic       key_multi;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned press_seen = 0;
  int unsigned base;

  key_encode_83 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keyin     (keyin),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_press (key_press),
    .key_multi (key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later; counts strobes seen.
  task automatic tick();
    @(posedge clk);
    #1;
    if (key_press === 1'b1) press_seen++;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] code,
                               input logic valid, input logic press, input logic multi);
    check({tag, ".code"},  32'(key_code),  32'(code));
    check({tag, ".valid"}, 32'(key_valid), 32'(valid));
    check({tag, ".press"}, 32'(key_press), 32'(press));
    check({tag, ".multi"}, 32'(key_multi), 32'(multi));
  endtask

  // Drive a pattern that is stable from edge 1; press must appear at edge 7.
  task automatic press_and_check(input string tag, input logic [7:0] k,
                                 input logic [2:0] code, input logic multi);
    keyin = k;
    ticks(6);
    check({tag, ".early_press"}, 32'(key_press), 32'd0);
    check({tag, ".early_valid"}, 32'(key_valid), 32'd0);
    tick();
    check_outputs({tag, ".edge7"}, code, 1'b1, 1'b1, multi);
    tick();
    check({tag, ".strobe_width"}, 32'(key_press), 32'd0);
    check({tag, ".valid_hold"},   32'(key_valid), 32'd1);
  endtask

  task automatic release_and_check(input string tag, input logic [2:0] code);
    keyin = 8'hFF;
    ticks(6);
    check({tag, ".rel_early_valid"}, 32'(key_valid), 32'd1);
    tick();
    check({tag, ".rel_valid"}, 32'(key_valid), 32'd0);
    check({tag, ".rel_code"},  32'(key_code),  32'(code));
  endtask

  initial begin
    rst_n = 1'b0;
    keyin = 8'hFF;
    #12;
    check_outputs("reset_init", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ticks(3);
    check_outputs("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

    // Single press of key 5.
    base = press_seen;
    press_and_check("single", 8'b1101_1111, 3'd5, 1'b0);
    ticks(3);
    release_and_check("single", 3'd5);
    check("single.press_count", press_seen - base, 32'd1);

    // Bounce on key 2: six 2-cycle segments, then held low.
    base = press_seen;
    for (int unsigned s = 0; s < 6; s++) begin
      keyin = (s % 2 == 0) ? 8'b1111_1011 : 8'hFF;
      ticks(2);
    end
    check("bounce.no_press_during", press_seen - base, 32'd0);
    press_and_check("bounce", 8'b1111_1011, 3'd2, 1'b0);
    check("bounce.press_count", press_seen - base, 32'd1);
    release_and_check("bounce", 3'd2);

    // Multi-key: keys 2, 4, 7.
    base = press_seen;
    press_and_check("multi", 8'b0110_1011, 3'd2, 1'b1);
    ticks(5);
    check("multi.press_count", press_seen - base, 32'd1);
    release_and_check("multi", 3'd2);

    // Release glitch while holding key 3.
    base = press_seen;
    press_and_check("glitch", 8'b1111_0111, 3'd3, 1'b0);
    keyin = 8'hFF;
    tick();
    check("glitch.valid_g1", 32'(key_valid), 32'd1);
    tick();
    check("glitch.valid_g2", 32'(key_valid), 32'd1);
    keyin = 8'b1111_0111;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("glitch.valid_after", 32'(key_valid), 32'd1);
    end
    check("glitch.press_count", press_seen - base, 32'd1);
    check("glitch.code", 32'(key_code), 32'd3);

    // Asynchronous reset while HELD, between edges.
    keyin = 8'hFF;
    rst_n = 1'b0;
    #2;
    check_outputs("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(8);
    check_outputs("post_reset_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-debounce with key 6 held through it.
    base = press_seen;
    keyin = 8'b1011_1111;
    ticks(4);
    rst_n = 1'b0;
    #1;
    check_outputs("mid_db_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(6);
    check("mid_db.early_press", 32'(key_press), 32'd0);
    check("mid_db.early_valid", 32'(key_valid), 32'd0);
    tick();
    check_outputs("mid_db.edge7", 3'd6, 1'b1, 1'b1, 1'b0);
    tick();
    check("mid_db.strobe_width", 32'(key_press), 32'd0);
    check("mid_db.press_count", press_seen - base, 32'd1);
    release_and_check("mid_db", 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_encode_83.md
# key_encode_83

Debounced 8-to-3 keypad encoder: the input-side counterpart of the 3-to-8 LED decoder. It samples eight active-low key lines, removes contact bounce, and reports the pressed key as a 3-bit code with a level-valid flag and a one-cycle press strobe. Its output can drive the decoder directly, which turns one LED on per pressed key. It sits between the board push-buttons and any logic that consumes key codes.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: number of consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz). Legal range ≥ 2. The counter width is $clog2(DEBOUNCE_CYCLES).
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- keyin  input  8  raw key lines, active-low (0 = pressed); asynchronous to clk.
- key_code  output  3  encoded debounced key; holds its last value after release.
- key_valid  output  1  high while a debounced press is held.
- key_press  output  1  one-cycle strobe on each accepted press.
- key_multi  output  1  more than one key was down in the accepted press pattern; valid with key_valid.

## Operation
- Synchronizer: a two-flop chain on ~keyin gives key_s[7:0], where 1 = pressed. Only key_s feeds the FSM.
- Priority encoding: the lowest set index wins, so key_code = index of the lowest 1 in the captured pattern `pat`.
- key_multi = 1 when popcount(pat) > 1.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB. There is one counter `cnt` and one 8-bit register `pat`.
- IDLE:
  - key_s == 0: stay in IDLE.
  - key_s != 0: pat ← key_s, cnt ← 0, go to PRESS_DB.
- PRESS_DB:
  - key_s == 0: go to IDLE (bounce rejected).
  - key_s != 0 and key_s != pat: pat ← key_s, cnt ← 0, stay in PRESS_DB.
  - key_s == pat and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - key_s == pat and cnt == DEBOUNCE_CYCLES-1: go to HELD. Update key_code and key_multi from pat, set key_valid ← 1, and pulse key_press for one cycle.
- HELD:
  - key_s == pat: stay in HELD.
  - Otherwise: cnt ← 0, go to REL_DB.
- REL_DB:
  - key_s == pat: go back to HELD (release glitch absorbed). No new strobe, outputs unchanged.
  - key_s != 0 and key_s != pat: cnt ← 0, stay in REL_DB. A roll-over to a new key is not reported until a full release.
  - key_s == 0 and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - key_s == 0 and cnt == DEBOUNCE_CYCLES-1: key_valid ← 0, go to IDLE.
- key_code and key_multi change only on the PRESS_DB→HELD transition and are otherwise held.
- Asynchronous reset while rst_n is low, from any state:
  - state ← IDLE.
  - cnt, pat and both synchronizer flops ← 0.
  - key_code = 0, key_valid = 0, key_press = 0, key_multi = 0.
- Reset mid-debounce discards all progress. A key held through reset release is treated as a new press and must re-qualify over the full debounce window.

## Timing
- All outputs are registered. There is no combinational path from keyin to any output.
- Press latency: key_press and key_valid rise DEBOUNCE_CYCLES+3 rising edges after the first edge that samples keyin low, provided the key is stable. Breakdown: 2 synchronizer edges, 1 edge for IDLE→PRESS_DB, then DEBOUNCE_CYCLES edges of counting.
- Release latency: key_valid falls DEBOUNCE_CYCLES+3 edges after the first edge that samples all keys high, provided they stay stable.
- key_press is high for exactly one cycle per accepted press, and it is coincident with the first cycle in which key_valid = 1.
- A change in key_s resets the debounce window; the window restarts counting on the next edge.

## Test plan
- Reset: assert rst_n = 0 mid-simulation with keyin = 8'hFF. Required: all outputs 0 asynchronously, and FSM in IDLE after release.
- Single press/release, DEBOUNCE_CYCLES = 4: drive keyin = 8'b1101_1111 (key 5). Required:
  - key_press is a single one-cycle pulse at edge 7, with key_code = 5, key_valid = 1, key_multi = 0.
  - After release to 8'hFF, key_valid drops at edge 7 after release and key_code stays 5.
- Bounce: toggle key 2 every 2 cycles for 12 cycles, then hold it low. Required: exactly one key_press, arriving 7 edges after the last transition, with key_code = 2.
- Multi-key: drive keyin = 8'b0110_1011 (keys 2, 4, 7) stable. Required: key_code = 2, key_multi = 1, one key_press.
- Release glitch: in HELD with key 3, drive keyin high for 2 cycles, then low again. Required: key_valid stays 1 throughout and no second key_press.
- Reset mid-debounce: hold key 6 and pulse rst_n low at edge 4. Required:
  - Outputs go to 0 immediately.
  - After rst_n returns high with the key still held, key_press arrives 7 edges after the first sampling edge following reset, with key_code = 6.
